display_scroll_controller: RTL
==============================

Name: display_scroll_controller

Overview:
Sequences the six-digit seven-segment display bank by scrolling a stored message across it. A producer loads segment patterns through a valid/ready write port. Once loaded, the block steps a six-digit window across the message at a programmable rate. It drives the 42-bit packed display vector consumed by the display unmapper: disp0 (leftmost) is at bits [41:35] and disp5 at bits [6:0].

Parameters:
MSG_DEPTH, 16, maximum message length in characters (2..64).
TICK_DIV, 25000000, clk cycles per scroll step (>=1).
BLANK, 7'h7F, segment pattern for an unlit digit (active-low segments).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
wrValid  input  1  write data valid.
wrReady  output  1  controller can accept a write.
wrData  input  7  segment pattern for one character.
wrLast  input  1  marks final character of message; qualified by wrValid.
start  input  1  begin scrolling; level-sampled each cycle.
stop  input  1  halt scrolling, or discard message when not scrolling.
busy  output  1  high while in SCROLL.
wrapPulse  output  1  one-cycle pulse when scroll wraps to window 0.
vectorOut  output  42  packed display vector; digit k is at bits [41-7k -: 7].

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clk edge regardless of state; message contents are lost. Reset values:
  - state=IDLE, len=0, wrPtr=0, pos=0, tickCnt=0.
  - wrReady=1, busy=0, wrapPulse=0.
  - vectorOut={6{BLANK}}.
- FSM states: IDLE (accepting writes), LOADED (message complete), SCROLL.
- IDLE:
  - wrReady=1. An accepted write (wrValid&&wrReady) stores wrData at msg[wrPtr] and increments wrPtr.
  - If the accepted write has wrLast=1, or wrPtr==MSG_DEPTH-1: len<=wrPtr+1, go to LOADED.
  - start and stop are ignored.
- LOADED:
  - wrReady=0; writes are ignored. vectorOut holds {6{BLANK}}.
  - stop: go to IDLE, clear len and wrPtr.
  - Otherwise start: go to SCROLL, set pos=0 and tickCnt=0.
- SCROLL:
  - busy=1, wrReady=0; writes are ignored.
  - Stream definition: stream[i]=msg[i] for i<len, else BLANK.
  - Window(pos): digit k shows stream[pos+k], for k=0..5.
  - vectorOut is registered and loads window(pos) every cycle, i.e. one cycle of latency after a pos change. The first window appears on the edge after start is accepted.
  - tickCnt counts 0..TICK_DIV-1. At tickCnt==TICK_DIV-1: tickCnt<=0 and pos advances. A full step therefore takes exactly TICK_DIV cycles.
  - pos ranges 0..len. At pos==len the display is all blank.
  - Advancing from pos==len sets pos<=0 and raises wrapPulse for exactly one cycle, aligned with the vectorOut update showing window 0.
  - stop: go to LOADED; vectorOut<=BLANKs on the next edge; pos and tickCnt are cleared.
- start and stop in the same cycle: stop wins in every state.
- TICK_DIV=1: pos advances every cycle.
- len is always >=1 when LOADED; a length-0 message is unreachable.
- Window indexing never reads past len+5. Positions >=len yield BLANK and never index msg.
- Outputs have no combinational paths from inputs except wrReady, which is a decode of state.

Test Plan:
(Bench parameters: MSG_DEPTH=8, TICK_DIV=4, BLANK=7'h7F.)
1. Reset -> vectorOut=42'h3FFFFFFFFFF, wrReady=1, busy=0, wrapPulse=0.
2. Write 7'h01, 7'h02, 7'h03 with wrLast on the third, then pulse start.
   - Next edge: vectorOut={01,02,03,7F,7F,7F}.
   - After 4 cycles: {02,03,7F,7F,7F,7F}.
   - At 12 cycles: all 7F.
   - At 16 cycles: wrapPulse=1 for one cycle, vectorOut back to {01,02,03,7F,7F,7F}.
3. Write 8 characters with no wrLast.
   - wrReady=0 after the 8th accept; a 9th write is ignored.
   - Scroll shows characters 0..5 first; after 8 steps the display is all blank.
4. In LOADED, assert start and stop in the same cycle -> state IDLE, busy stays 0, wrReady=1. A new single-character message loads from msg[0].
5. In SCROLL, assert wrValid with wrData=7'h00 -> ignored. Then stop -> vectorOut all 7F and busy=0. Then start -> window 0 is redisplayed.
6. Assert reset mid-scroll at pos=2 -> next edge gives all reset values. start alone afterwards has no effect until a message is loaded.

Source files
------------

// File: rtl/display_scroll_controller.sv
// display_scroll_controller
//   Scrolls a stored message of seven-segment patterns across a six-digit
//   display bank. Characters are loaded through a valid/ready write port.
//   After loading, a six-digit window steps across the message once every
//   TICK_DIV cycles. The window runs past the end of the message through an
//   all-blank position and then wraps back to the start.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   wrValid    write data valid
//   wrReady    controller accepts a write (high only while idle)
//   wrData     segment pattern for one character
//   wrLast     final character of the message (qualified by wrValid)
//   start      begin scrolling (level-sampled)
//   stop       halt scrolling, or discard the loaded message when not scrolling
//   busy       high while scrolling
//   wrapPulse  one-cycle pulse that coincides with window 0 being redisplayed
//   vectorOut  packed display vector; digit k is at bits [41-7k -: 7]
module display_scroll_controller #(
  parameter int unsigned MSG_DEPTH = 16,
  parameter int unsigned TICK_DIV  = 25000000,
  parameter logic [6:0]  BLANK     = 7'h7F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wrValid,
  output logic        wrReady,
  input  logic [6:0]  wrData,
  input  logic        wrLast,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        wrapPulse,
  output logic [41:0] vectorOut
);

  localparam int unsigned AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int unsigned LW = $clog2(MSG_DEPTH + 1);
  localparam int unsigned IW = $clog2(MSG_DEPTH + 6);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [LW-1:0] LAST_PTR  = LW'(MSG_DEPTH - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [41:0]   BLANKS    = {6{BLANK}};

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SCROLL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [6:0]    msg [MSG_DEPTH];
  logic [LW-1:0] len;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] pos;
  logic [TW-1:0] tick_cnt;
  logic          wrap_pending;

  logic          wr_accept;
  logic          wr_final;
  logic          tick_end;
  logic [41:0]   window;
  logic [IW-1:0] idx;

  assign wr_accept = wrValid && (state == IDLE);
  assign wr_final  = wrLast || (wr_ptr == LAST_PTR);
  assign tick_end  = (tick_cnt == TICK_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop takes priority over start everywhere
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_accept && wr_final) begin
          state_nxt = LOADED;
        end
      end
      LOADED: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = SCROLL;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_nxt = LOADED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State decodes
  always_comb begin
    wrReady = (state == IDLE);
    busy    = (state == SCROLL);
  end

  // Message storage; contents are not reset
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      msg[wr_ptr[AW-1:0]] <= wrData;
    end
  end

  // Window at the current position. Positions at or past len are blank,
  // so msg is only read for indices strictly below len.
  always_comb begin
    window = BLANKS;
    idx    = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      idx = IW'(pos) + IW'(k);
      if (idx < IW'(len)) begin
        window[41 - 7*k -: 7] = msg[idx[AW-1:0]];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      len          <= '0;
      wr_ptr       <= '0;
      pos          <= '0;
      tick_cnt     <= '0;
      wrap_pending <= 1'b0;
      wrapPulse    <= 1'b0;
      vectorOut    <= BLANKS;
    end else begin
      unique case (state)
        IDLE: begin
          vectorOut    <= BLANKS;
          wrapPulse    <= 1'b0;
          wrap_pending <= 1'b0;
          if (wr_accept) begin
            wr_ptr <= wr_ptr + LW'(1);
            if (wr_final) begin
              len <= wr_ptr + LW'(1);
            end
          end
        end
        LOADED: begin
          vectorOut    <= BLANKS;
          wrapPulse    <= 1'b0;
          wrap_pending <= 1'b0;
          if (stop) begin
            len    <= '0;
            wr_ptr <= '0;
          end else if (start) begin
            pos      <= '0;
            tick_cnt <= '0;
          end
        end
        SCROLL: begin
          if (stop) begin
            vectorOut    <= BLANKS;
            pos          <= '0;
            tick_cnt     <= '0;
            wrapPulse    <= 1'b0;
            wrap_pending <= 1'b0;
          end else begin
            vectorOut <= window;
            // The wrap is flagged when pos returns to 0 and emitted one
            // cycle later, together with the registered window 0.
            wrapPulse    <= wrap_pending;
            wrap_pending <= 1'b0;
            if (tick_end) begin
              tick_cnt <= '0;
              if (pos == len) begin
                pos          <= '0;
                wrap_pending <= 1'b1;
              end else begin
                pos <= pos + LW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          vectorOut <= BLANKS;
          wrapPulse <= 1'b0;
        end
      endcase
    end
  end

endmodule
